// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoded ID fields, MEM-stage hazard inputs and the
// registered EX-side outputs, plus the hazard stall and bubble counter.
interface id_ex_stage_if;
  // ID-side control and data
  logic        RegWrite_in;
  logic        MemWrite_in;
  logic        ALUSrc_in;
  logic        MemRead_in;
  logic        Branch_in;
  logic [2:0]  ALUOp_in;
  logic [31:0] RS1data_in;
  logic [31:0] RS2data_in;
  logic [31:0] Imm_in;
  logic [4:0]  RS1addr_in;
  logic [4:0]  RS2addr_in;
  logic [4:0]  RDaddr_in;
  // MEM-stage view used by the branch hazard rule
  logic        MEM_MemRead_in;
  logic [4:0]  MEM_RDaddr_in;
  // EX-side registered outputs
  logic        RegWrite_out;
  logic        MemWrite_out;
  logic        ALUSrc_out;
  logic        MemRead_out;
  logic [2:0]  ALUOp_out;
  logic [31:0] RS1data_out;
  logic [31:0] RS2data_out;
  logic [31:0] Imm_out;
  logic [4:0]  RS1addr_out;
  logic [4:0]  RS2addr_out;
  logic [4:0]  RDaddr_out;
  logic        Stall_out;
  logic [15:0] BubbleCount_out;

  // Pipeline stage side
  modport slave (
    input  RegWrite_in, MemWrite_in, ALUSrc_in, MemRead_in, Branch_in, ALUOp_in,
    input  RS1data_in, RS2data_in, Imm_in, RS1addr_in, RS2addr_in, RDaddr_in,
    input  MEM_MemRead_in, MEM_RDaddr_in,
    output RegWrite_out, MemWrite_out, ALUSrc_out, MemRead_out, ALUOp_out,
    output RS1data_out, RS2data_out, Imm_out, RS1addr_out, RS2addr_out, RDaddr_out,
    output Stall_out, BubbleCount_out
  );

  // Decode / surrounding pipeline side
  modport master (
    output RegWrite_in, MemWrite_in, ALUSrc_in, MemRead_in, Branch_in, ALUOp_in,
    output RS1data_in, RS2data_in, Imm_in, RS1addr_in, RS2addr_in, RDaddr_in,
    output MEM_MemRead_in, MEM_RDaddr_in,
    input  RegWrite_out, MemWrite_out, ALUSrc_out, MemRead_out, ALUOp_out,
    input  RS1data_out, RS2data_out, Imm_out, RS1addr_out, RS2addr_out, RDaddr_out,
    input  Stall_out, BubbleCount_out
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use and branch-operand hazard detection.
// A detected hazard stalls PC/IF/ID (externally) and turns this edge's capture
// into a bubble; bubbles are tallied in a saturating 16-bit counter.
module id_ex_stage (
  input logic          clk_i,
  input logic          rst_i,
  id_ex_stage_if.slave bus
);

  logic        r_regwrite;
  logic        r_memwrite;
  logic        r_alusrc;
  logic        r_memread;
  logic [2:0]  r_aluop;
  logic [31:0] r_rs1data;
  logic [31:0] r_rs2data;
  logic [31:0] r_imm;
  logic [4:0]  r_rs1addr;
  logic [4:0]  r_rs2addr;
  logic [4:0]  r_rdaddr;
  logic [15:0] r_bubble_cnt;

  logic        w_load_use;
  logic        w_br_ex;
  logic        w_br_mem;
  logic        w_stall;

  // Nonzero destination that the ID instruction reads; RS2 is compared even
  // for I-type, accepting an occasional false stall.
  function automatic logic f_match(input logic [4:0] a,
                                   input logic [4:0] rs1,
                                   input logic [4:0] rs2);
    f_match = (a != 5'd0) && ((a == rs1) || (a == rs2));
  endfunction

  // Hazard detection from EX registers and ID/MEM inputs in the same cycle
  always_comb begin
    w_load_use = r_memread && f_match(r_rdaddr, bus.RS1addr_in, bus.RS2addr_in);
    w_br_ex    = bus.Branch_in && r_regwrite &&
                 f_match(r_rdaddr, bus.RS1addr_in, bus.RS2addr_in);
    w_br_mem   = bus.Branch_in && bus.MEM_MemRead_in &&
                 f_match(bus.MEM_RDaddr_in, bus.RS1addr_in, bus.RS2addr_in);
    w_stall    = w_load_use || w_br_ex || w_br_mem;
  end

  // Capture ID fields, or insert a bubble (controls/addresses zero, data held)
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_regwrite   <= 1'b0;
      r_memwrite   <= 1'b0;
      r_alusrc     <= 1'b0;
      r_memread    <= 1'b0;
      r_aluop      <= 3'd0;
      r_rs1data    <= 32'd0;
      r_rs2data    <= 32'd0;
      r_imm        <= 32'd0;
      r_rs1addr    <= 5'd0;
      r_rs2addr    <= 5'd0;
      r_rdaddr     <= 5'd0;
      r_bubble_cnt <= 16'd0;
    end else if (w_stall) begin
      r_regwrite <= 1'b0;
      r_memwrite <= 1'b0;
      r_alusrc   <= 1'b0;
      r_memread  <= 1'b0;
      r_aluop    <= 3'd0;
      r_rs1addr  <= 5'd0;
      r_rs2addr  <= 5'd0;
      r_rdaddr   <= 5'd0;
      r_rs1data  <= r_rs1data;
      r_rs2data  <= r_rs2data;
      r_imm      <= r_imm;
      if (r_bubble_cnt != 16'hFFFF) begin
        r_bubble_cnt <= r_bubble_cnt + 16'd1;
      end else begin
        r_bubble_cnt <= r_bubble_cnt;
      end
    end else begin
      r_regwrite   <= bus.RegWrite_in;
      r_memwrite   <= bus.MemWrite_in;
      r_alusrc     <= bus.ALUSrc_in;
      r_memread    <= bus.MemRead_in;
      r_aluop      <= bus.ALUOp_in;
      r_rs1data    <= bus.RS1data_in;
      r_rs2data    <= bus.RS2data_in;
      r_imm        <= bus.Imm_in;
      r_rs1addr    <= bus.RS1addr_in;
      r_rs2addr    <= bus.RS2addr_in;
      r_rdaddr     <= bus.RDaddr_in;
      r_bubble_cnt <= r_bubble_cnt;
    end
  end

  assign bus.RegWrite_out    = r_regwrite;
  assign bus.MemWrite_out    = r_memwrite;
  assign bus.ALUSrc_out      = r_alusrc;
  assign bus.MemRead_out     = r_memread;
  assign bus.ALUOp_out       = r_aluop;
  assign bus.RS1data_out     = r_rs1data;
  assign bus.RS2data_out     = r_rs2data;
  assign bus.Imm_out         = r_imm;
  assign bus.RS1addr_out     = r_rs1addr;
  assign bus.RS2addr_out     = r_rs2addr;
  assign bus.RDaddr_out      = r_rdaddr;
  assign bus.Stall_out       = w_stall;
  assign bus.BubbleCount_out = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: scenario tasks push the expected EX
// contents when they drive ID, and pop/compare after the capturing edge.
module tb_id_ex_stage;

  typedef struct packed {
    logic        rw;
    logic        mw;
    logic        as;
    logic        mr;
    logic [2:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] im;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  rd;
  } ex_t;

  logic        clk;
  logic        rst_n;
  ex_t         q[$];
  ex_t         model;
  logic [15:0] exp_cnt;
  int          total;
  int          bad;

  id_ex_stage_if bus ();

  id_ex_stage u_dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ex_t mk(input logic rw, input logic mw, input logic as,
                             input logic mr, input logic [2:0] op,
                             input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] im, input logic [4:0] a1,
                             input logic [4:0] a2, input logic [4:0] rd);
    ex_t e;
    e.rw = rw; e.mw = mw; e.as = as; e.mr = mr; e.op = op;
    e.d1 = d1; e.d2 = d2; e.im = im; e.a1 = a1; e.a2 = a2; e.rd = rd;
    return e;
  endfunction

  function automatic ex_t sample();
    ex_t e;
    e.rw = bus.RegWrite_out; e.mw = bus.MemWrite_out; e.as = bus.ALUSrc_out;
    e.mr = bus.MemRead_out;  e.op = bus.ALUOp_out;
    e.d1 = bus.RS1data_out;  e.d2 = bus.RS2data_out;  e.im = bus.Imm_out;
    e.a1 = bus.RS1addr_out;  e.a2 = bus.RS2addr_out;  e.rd = bus.RDaddr_out;
    return e;
  endfunction

  task automatic drive(input ex_t s, input logic br, input logic mmr,
                       input logic [4:0] mrd);
    bus.RegWrite_in    = s.rw;
    bus.MemWrite_in    = s.mw;
    bus.ALUSrc_in      = s.as;
    bus.MemRead_in     = s.mr;
    bus.ALUOp_in       = s.op;
    bus.RS1data_in     = s.d1;
    bus.RS2data_in     = s.d2;
    bus.Imm_in         = s.im;
    bus.RS1addr_in     = s.a1;
    bus.RS2addr_in     = s.a2;
    bus.RDaddr_in      = s.rd;
    bus.Branch_in      = br;
    bus.MEM_MemRead_in = mmr;
    bus.MEM_RDaddr_in  = mrd;
  endtask

  // One pipeline cycle: drive ID, check stall, push expectation, compare after edge
  task automatic cycle(input string name, input ex_t s, input logic br,
                       input logic mmr, input logic [4:0] mrd, input logic exp_stall);
    ex_t e;
    ex_t o;
    @(negedge clk);
    drive(s, br, mmr, mrd);
    #1;
    total++;
    if (bus.Stall_out !== exp_stall) begin
      bad++;
      $display("FAIL %s.stall got=%b want=%b", name, bus.Stall_out, exp_stall);
    end
    if (exp_stall) begin
      e = '0;
      e.d1 = model.d1; e.d2 = model.d2; e.im = model.im;
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end else begin
      e = s;
    end
    q.push_back(e);
    model = e;
    @(posedge clk);
    #1;
    e = q.pop_front();
    o = sample();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL %s.ex got=%h want=%h", name, o, e);
    end
    total++;
    if (bus.BubbleCount_out !== exp_cnt) begin
      bad++;
      $display("FAIL %s.count got=%h want=%h", name, bus.BubbleCount_out, exp_cnt);
    end
  endtask

  task automatic test_reset();
    ex_t r;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      r = mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             3'($urandom), $urandom, $urandom, $urandom,
             5'($urandom), 5'($urandom), 5'($urandom));
      drive(r, 1'b0, 1'($urandom), 5'($urandom));
      #1;
      total++;
      if (sample() !== ex_t'('0)) begin
        bad++;
        $display("FAIL reset.ex got=%h want=0", sample());
      end
      total++;
      if (bus.Stall_out !== 1'b0) begin
        bad++;
        $display("FAIL reset.stall got=%b want=0", bus.Stall_out);
      end
      total++;
      if (bus.BubbleCount_out !== 16'd0) begin
        bad++;
        $display("FAIL reset.count got=%h want=0", bus.BubbleCount_out);
      end
    end
    model = '0;
    exp_cnt = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle("reset_release", mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 32'd0, 32'd0, 32'd0,
                              5'd0, 5'd0, 5'd7), 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic test_load_use();
    ex_t lw5;
    ex_t add6;
    lw5  = mk(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 32'h100, 32'h0, 32'h8, 5'd2, 5'd0, 5'd5);
    add6 = mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 32'h11, 32'h22, 32'h0, 5'd5, 5'd7, 5'd6);
    cycle("lu_lw", lw5, 1'b0, 1'b0, 5'd0, 1'b0);
    cycle("lu_stall", add6, 1'b0, 1'b0, 5'd0, 1'b1);
    cycle("lu_add", add6, 1'b0, 1'b1, 5'd5, 1'b0);
  endtask

  task automatic test_x0();
    cycle("x0_lw", mk(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 32'h4, 32'h0, 32'h4,
                      5'd1, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 1'b0);
    cycle("x0_use", mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 32'h0, 32'h0, 32'h0,
                       5'd0, 5'd0, 5'd6), 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic test_branch();
    ex_t add3;
    ex_t lw3;
    ex_t beq;
    add3 = mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 32'h5, 32'h6, 32'h0, 5'd1, 5'd2, 5'd3);
    lw3  = mk(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 32'h40, 32'h0, 32'h10, 5'd1, 5'd0, 5'd3);
    beq  = mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 32'h33, 32'h44, 32'h20, 5'd3, 5'd4, 5'd0);
    // ALU producer: one bubble
    cycle("br_alu_add", add3, 1'b0, 1'b0, 5'd0, 1'b0);
    cycle("br_alu_stall", beq, 1'b1, 1'b0, 5'd0, 1'b1);
    cycle("br_alu_go", beq, 1'b1, 1'b0, 5'd0, 1'b0);
    // Load producer: EX-writer bubble then MEM-load bubble
    cycle("br_ld_lw", lw3, 1'b0, 1'b0, 5'd0, 1'b0);
    cycle("br_ld_stall1", beq, 1'b1, 1'b0, 5'd0, 1'b1);
    cycle("br_ld_stall2", beq, 1'b1, 1'b1, 5'd3, 1'b1);
    cycle("br_ld_go", beq, 1'b1, 1'b0, 5'd0, 1'b0);
    total++;
    if (bus.BubbleCount_out !== 16'd4) begin
      bad++;
      $display("FAIL br_total got=%0d want=4", bus.BubbleCount_out);
    end
  endtask

  task automatic test_back_to_back();
    ex_t r;
    for (int i = 0; i < 8; i++) begin
      r = mk(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 3'($urandom),
             $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
      cycle("b2b", r, 1'b0, 1'($urandom), 5'($urandom), 1'b0);
    end
  endtask

  task automatic test_saturation();
    ex_t beq;
    int  n;
    beq = mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 32'h1, 32'h2, 32'h3, 5'd9, 5'd4, 5'd0);
    @(negedge clk);
    drive(beq, 1'b1, 1'b1, 5'd9);
    n = 32'hFFFE - int'(exp_cnt);
    repeat (n) @(posedge clk);
    #1;
    exp_cnt = 16'hFFFE;
    model.rw = 1'b0; model.mw = 1'b0; model.as = 1'b0; model.mr = 1'b0;
    model.op = 3'd0; model.a1 = 5'd0; model.a2 = 5'd0; model.rd = 5'd0;
    total++;
    if (bus.BubbleCount_out !== 16'hFFFE) begin
      bad++;
      $display("FAIL sat_preload got=%h want=fffe", bus.BubbleCount_out);
    end
    for (int i = 0; i < 3; i++) begin
      cycle("sat", beq, 1'b1, 1'b1, 5'd9, 1'b1);
    end
    total++;
    if (bus.BubbleCount_out !== 16'hFFFF) begin
      bad++;
      $display("FAIL sat_hold got=%h want=ffff", bus.BubbleCount_out);
    end
  endtask

  task automatic test_reset_mid_stall();
    ex_t lw5;
    ex_t add6;
    lw5  = mk(1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 32'hAA, 32'hBB, 32'hCC, 5'd2, 5'd3, 5'd5);
    add6 = mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 32'h11, 32'h22, 32'h0, 5'd5, 5'd7, 5'd6);
    cycle("rms_lw", lw5, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    drive(add6, 1'b0, 1'b0, 5'd0);
    #1;
    total++;
    if (bus.Stall_out !== 1'b1) begin
      bad++;
      $display("FAIL rms_stall got=%b want=1", bus.Stall_out);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (sample() !== ex_t'('0)) begin
      bad++;
      $display("FAIL rms_clear got=%h want=0", sample());
    end
    total++;
    if (bus.BubbleCount_out !== 16'd0 || bus.Stall_out !== 1'b0) begin
      bad++;
      $display("FAIL rms_cnt_stall got=%h/%b want=0/0", bus.BubbleCount_out, bus.Stall_out);
    end
    q.delete();
    model = '0;
    exp_cnt = 16'd0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle("rms_release", add6, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    model = '0;
    exp_cnt = 16'd0;
    rst_n = 1'b0;
    drive(ex_t'('0), 1'b0, 1'b0, 5'd0);
    test_reset();
    test_load_use();
    test_x0();
    test_branch();
    test_back_to_back();
    test_saturation();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated hazard detection for the five-stage RISC-V core. It captures the decoded control bits, operand data, immediate and register addresses produced in ID, and presents them to EX on the next cycle. It detects load-use and branch-operand hazards, stalling PC and IF/ID and inserting a bubble into EX. A saturating counter records bubble cycles for performance bring-up.

## Interface
Parameters: none.
- clk_i  in  1  rising-edge clock
- rst_i  in  1  asynchronous reset, active-low
- RegWrite_in, MemWrite_in, ALUSrc_in, MemRead_in  in  1 each  ID control bits, already zeroed by decode on flush
- Branch_in  in  1  ID instruction is a branch; branches resolve in ID
- ALUOp_in  in  3  ID ALU operation code
- RS1data_in, RS2data_in, Imm_in  in  32 each  ID operands and immediate
- RS1addr_in, RS2addr_in, RDaddr_in  in  5 each  ID register fields (instr[19:15], [24:20], [11:7])
- MEM_MemRead_in  in  1  instruction currently in MEM is a load
- MEM_RDaddr_in  in  5  destination of the instruction in MEM
- RegWrite_out, MemWrite_out, ALUSrc_out, MemRead_out  out  1 each  EX control bits
- ALUOp_out  out  3  EX ALU operation code
- RS1data_out, RS2data_out, Imm_out  out  32 each  EX operands
- RS1addr_out, RS2addr_out, RDaddr_out  out  5 each  EX register fields, also used by forwarding
- Stall_out  out  1  combinational; freezes PC and IF/ID and forces a bubble here
- BubbleCount_out  out  16  saturating count of inserted bubbles

## Operation
- Define `match(a)` as `a != 0 && (a == RS1addr_in || a == RS2addr_in)`. RS2 is compared for every format. False stalls on I-type instructions are accepted.
- Stall_out is asserted when any of these hold:
  - load-use: `MemRead_out && match(RDaddr_out)`;
  - branch vs EX writer: `Branch_in && RegWrite_out && match(RDaddr_out)`;
  - branch vs MEM load: `Branch_in && MEM_MemRead_in && match(MEM_RDaddr_in)`.
- Register x0 never causes a stall.
- Normal cycle (Stall_out=0): every *_out register loads its *_in counterpart.
- Bubble cycle (Stall_out=1):
  - RegWrite, MemWrite, MemRead and ALUSrc load 0; ALUOp loads 0; RDaddr, RS1addr and RS2addr load 0.
  - RS1data, RS2data and Imm hold their values. Their content is don't-care because all control bits are 0.
  - BubbleCount increments by 1 and saturates at 0xFFFF; it never wraps.
- Stall handling for ID/IF is external: while Stall_out=1, ID presents the same instruction again on the next cycle, and hazard detection re-evaluates against the new EX and MEM contents.
- A branch that depends on a load stalls 2 cycles: EX-writer rule first, then MEM-load rule. A branch that depends on an ALU op stalls 1 cycle.
- A flushed ID slot arrives with all-zero controls and Branch_in=0. It passes through as a normal cycle and cannot itself stall.

## Timing
- Reset (rst_i=0, asynchronous, independent of clk_i): all control outputs 0, ALUOp_out 0, all data and address outputs 0, BubbleCount_out 0. Stall_out then evaluates to 0 because MemRead_out and RegWrite_out are 0.
- Reset asserted during a stall cancels the bubble. After release, the first edge is a normal capture.
- Latency: 1 cycle from ID inputs to EX outputs.
- Stall_out has a combinational path from the registered outputs and the ID/MEM inputs, within the same cycle. There is no path from Stall_out back into hazard detection.
- Stall_out and the bubble take effect on the same edge: the edge that would have captured the stalled instruction captures the bubble instead.

## Test plan
- Reset: hold rst_i=0 with random inputs toggling -> all outputs 0, Stall_out=0, BubbleCount_out=0. Release rst_i; next edge captures `RDaddr_in=7`, `ALUOp_in=4` -> outputs 7 and 4.
- Load-use: EX holds `lw x5`; ID presents `add x6,x5,x7`.
  - Same cycle -> Stall_out=1.
  - Next edge -> MemRead_out=0, RegWrite_out=0, RDaddr_out=0, BubbleCount_out=1, Stall_out=0.
  - Following edge -> the add is captured with RDaddr_out=6.
- x0 immunity: EX holds `lw x0`; ID reads x0 -> Stall_out=0 and no bubble.
- Branch hazards:
  - EX holds `add x3`, ID holds `beq x3,x4` -> exactly 1 bubble.
  - EX holds `lw x3`, ID holds `beq x3,x4` -> 2 consecutive bubbles; BubbleCount_out advances by 2.
- Saturation: preload the counter to 0xFFFE and force 3 bubbles -> the count reads 0xFFFF and stays there.
- Reset mid-stall: assert rst_i while Stall_out=1 -> outputs clear immediately, without waiting for the clock edge.
